// File: rtl/alu_trojan_monitor_pkg.sv
// Shared definitions for the ALU trojan monitor: opcodes, FSM states and the
// packed expected-response record produced by the golden model.
package alu_mon_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    MON_MONITOR = 2'd0,
    MON_SUSPECT = 2'd1,
    MON_ALARM   = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] res;
    logic                 carry;
    logic                 zero;
    logic                 overflow;
  } alu_expected_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/alu_trojan_monitor_golden.sv
// Combinational reference model of the 4-bit ALU; maps operands and opcode to
// the result and flags the real ALU must produce.
module alu_golden_model
  import alu_mon_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output alu_expected_t    expected
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  // Carry on SUB is the unsigned borrow, not the adder carry-out.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = a - b;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res   = diff;
        carry = (a < b);
        ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      default: res = '0;
    endcase
  end

  assign expected = '{res: res, carry: carry, zero: (res == '0), overflow: ovf};

endmodule

// File: rtl/alu_trojan_monitor.sv
// Passive checker that compares ALU outputs against a delayed golden model and
// escalates repeated mismatches to a sticky alarm. Macro ALU_MON_CAPTURE_EN adds first-mismatch capture.
module alu_trojan_monitor
  import alu_mon_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int LATENCY       = 1,
  parameter int STRIKE_THRESH = 3,
  parameter int WINDOW        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dut_result,
  input  logic             dut_carry,
  input  logic             dut_zero,
  input  logic             dut_overflow,
  input  logic             clear_alarm,
  output logic             mismatch,
  output logic             alarm,
  output logic [1:0]       state,
  output logic [15:0]      check_count,
  output logic [15:0]      mismatch_count
`ifdef ALU_MON_CAPTURE_EN
  ,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_A,
  output logic [WIDTH-1:0] cap_B,
  output logic [1:0]       cap_op,
  output logic [WIDTH-1:0] cap_result
`endif
);

  localparam logic [3:0] THRESH_L = 4'(STRIKE_THRESH);
  localparam logic [7:0] WINDOW_L = 8'(WINDOW);

  alu_expected_t issue_exp;
  alu_expected_t dl_exp [LATENCY];
  logic [LATENCY-1:0] dl_valid;
  alu_expected_t dut_obs;
  logic compare;
  logic miss_now;

  mon_state_e state_q, state_d;
  logic [3:0] strikes_q, strikes_d;
  logic [7:0] window_q, window_d;

  alu_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a        (A),
    .b        (B),
    .op       (op),
    .expected (issue_exp)
  );

  // Only the valid bits need reset; stale payload behind a cleared valid is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) dl_valid[i] <= dl_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_exp[0] <= issue_exp;
    for (int i = 1; i < LATENCY; i++) dl_exp[i] <= dl_exp[i-1];
  end

`ifdef ALU_MON_CAPTURE_EN
  logic [WIDTH-1:0] dl_a  [LATENCY];
  logic [WIDTH-1:0] dl_b  [LATENCY];
  logic [1:0]       dl_op [LATENCY];

  always_ff @(posedge clk) begin
    dl_a[0]  <= A;
    dl_b[0]  <= B;
    dl_op[0] <= op;
    for (int i = 1; i < LATENCY; i++) begin
      dl_a[i]  <= dl_a[i-1];
      dl_b[i]  <= dl_b[i-1];
      dl_op[i] <= dl_op[i-1];
    end
  end
`endif

  assign compare  = dl_valid[LATENCY-1];
  assign dut_obs  = '{res: dut_result, carry: dut_carry, zero: dut_zero, overflow: dut_overflow};
  assign miss_now = compare && (dut_obs != dl_exp[LATENCY-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch       <= 1'b0;
      check_count    <= '0;
      mismatch_count <= '0;
    end else begin
      mismatch <= miss_now;
      if (compare)  check_count    <= sat_inc16(check_count);
      if (miss_now) mismatch_count <= sat_inc16(mismatch_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MON_MONITOR;
      strikes_q <= '0;
      window_q  <= '0;
    end else begin
      state_q   <= state_d;
      strikes_q <= strikes_d;
      window_q  <= window_d;
    end
  end

  // clear_alarm overrides any same-cycle mismatch; ALARM beats window expiry.
  always_comb begin
    state_d   = state_q;
    strikes_d = strikes_q;
    window_d  = window_q;
    if (clear_alarm) begin
      state_d   = MON_MONITOR;
      strikes_d = '0;
      window_d  = '0;
    end else begin
      unique case (state_q)
        MON_MONITOR: begin
          if (miss_now) begin
            state_d   = (STRIKE_THRESH == 1) ? MON_ALARM : MON_SUSPECT;
            strikes_d = 4'd1;
            window_d  = '0;
          end
        end
        MON_SUSPECT: begin
          if (compare) begin
            window_d  = window_q + 8'd1;
            strikes_d = strikes_q + {3'b000, miss_now};
            if (strikes_d >= THRESH_L) begin
              state_d = MON_ALARM;
            end else if (window_d >= WINDOW_L) begin
              state_d   = MON_MONITOR;
              strikes_d = '0;
              window_d  = '0;
            end
          end
        end
        MON_ALARM: state_d = MON_ALARM;
        default: begin
          state_d   = MON_MONITOR;
          strikes_d = '0;
          window_d  = '0;
        end
      endcase
    end
  end

  assign alarm = (state_q == MON_ALARM);
  assign state = state_q;

`ifdef ALU_MON_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid  <= 1'b0;
      cap_A      <= '0;
      cap_B      <= '0;
      cap_op     <= '0;
      cap_result <= '0;
    end else if (clear_alarm) begin
      cap_valid <= 1'b0;
    end else if (miss_now && !cap_valid) begin
      cap_valid  <= 1'b1;
      cap_A      <= dl_a[LATENCY-1];
      cap_B      <= dl_b[LATENCY-1];
      cap_op     <= dl_op[LATENCY-1];
      cap_result <= dut_result;
    end
  end
`endif

endmodule

// File: tb/tb_alu_trojan_monitor.sv
// Scoreboard bench for alu_trojan_monitor: directed ALU responses with hand-computed
// mismatch expectations, checked by a monitor whenever a compare is reported.
module tb_alu_trojan_monitor;
  import alu_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  A = '0;
  logic [3:0]  B = '0;
  logic [1:0]  op = '0;
  logic [3:0]  dut_result = '0;
  logic        dut_carry = 1'b0;
  logic        dut_zero = 1'b0;
  logic        dut_overflow = 1'b0;
  logic        clear_alarm = 1'b0;
  logic        mismatch;
  logic        alarm;
  logic [1:0]  state;
  logic [15:0] check_count;
  logic [15:0] mismatch_count;
`ifdef ALU_MON_CAPTURE_EN
  logic        cap_valid;
  logic [3:0]  cap_A;
  logic [3:0]  cap_B;
  logic [1:0]  cap_op;
  logic [3:0]  cap_result;
`endif

  int total = 0;
  int bad = 0;
  logic sb_q[$];
  int model_checks = 0;
  int model_misses = 0;
  logic [15:0] prev_cc = '0;
  logic mon_em;
  logic [3:0] pend_res = '0;
  logic pend_c = 1'b0, pend_z = 1'b0, pend_v = 1'b0;

  alu_trojan_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .A              (A),
    .B              (B),
    .op             (op),
    .dut_result     (dut_result),
    .dut_carry      (dut_carry),
    .dut_zero       (dut_zero),
    .dut_overflow   (dut_overflow),
    .clear_alarm    (clear_alarm),
    .mismatch       (mismatch),
    .alarm          (alarm),
    .state          (state),
    .check_count    (check_count),
    .mismatch_count (mismatch_count)
`ifdef ALU_MON_CAPTURE_EN
    ,
    .cap_valid      (cap_valid),
    .cap_A          (cap_A),
    .cap_B          (cap_B),
    .cap_op         (cap_op),
    .cap_result     (cap_result)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Each step drives the ALU response for the previous step's issue (LATENCY=1).
  task automatic apply_stimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                                input logic [1:0] o, input logic [3:0] r_res, input logic r_c,
                                input logic r_z, input logic r_v, input logic exp_miss,
                                input logic clr, input logic rs);
    @(posedge clk);
    #1;
    in_valid     = v;
    A            = a;
    B            = b;
    op           = o;
    clear_alarm  = clr;
    rst          = rs;
    dut_result   = pend_res;
    dut_carry    = pend_c;
    dut_zero     = pend_z;
    dut_overflow = pend_v;
    if (v) begin
      pend_res = r_res;
      pend_c   = r_c;
      pend_z   = r_z;
      pend_v   = r_v;
      sb_q.push_back(exp_miss);
    end else begin
      pend_res = '0;
      pend_c   = 1'b0;
      pend_z   = 1'b0;
      pend_v   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                       input logic [3:0] r_res, input logic r_c, input logic r_z,
                       input logic r_v, input logic exp_miss);
    apply_stimulus(1'b1, a, b, o, r_res, r_c, r_z, r_v, exp_miss, 1'b0, 1'b0);
  endtask

  task automatic settle();
    idle(2);
    @(negedge clk);
  endtask

  // Pops one expectation per reported compare; a pulse without a compare is an error.
  always @(negedge clk) begin
    if (!rst) begin
      if (check_count !== prev_cc) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_compare: check_count=%0d with empty scoreboard", check_count);
        end else begin
          mon_em = sb_q.pop_front();
          model_checks++;
          if (mon_em) model_misses++;
          check_output("mismatch_pulse", {15'b0, mismatch}, {15'b0, mon_em});
          check_output("check_count_track", check_count, 16'(model_checks));
          check_output("mismatch_count_track", mismatch_count, 16'(model_misses));
        end
      end else if (mismatch === 1'b1) begin
        total++;
        bad++;
        $display("[TB] FAIL stray_mismatch: got 1, want 0 (no compare this cycle)");
      end
    end
    prev_cc = check_count;
    if (rst) begin
      sb_q.delete();
      model_checks = 0;
      model_misses = 0;
      prev_cc      = '0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    apply_stimulus(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_output("reset_state", {14'b0, state}, 16'd0);
    check_output("reset_alarm", {15'b0, alarm}, 16'd0);
    check_output("reset_mismatch", {15'b0, mismatch}, 16'd0);
    check_output("reset_check_count", check_count, 16'd0);
    check_output("reset_mismatch_count", mismatch_count, 16'd0);
`ifdef ALU_MON_CAPTURE_EN
    check_output("reset_cap_valid", {15'b0, cap_valid}, 16'd0);
`endif
    idle(1);

    // Clean ADD 7+1 = 8, overflow set
    issue(4'h7, 4'h1, OP_ADD, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check_output("add_clean_state", {14'b0, state}, 16'd0);
    check_output("add_clean_checks", check_count, 16'd1);

    // SUB 2-3 = F with borrow; DUT drops the borrow
    issue(4'h2, 4'h3, OP_SUB, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    check_output("sub_bad_state", {14'b0, state}, 16'd1);
    check_output("sub_bad_mcount", mismatch_count, 16'd1);

    // Window expiry: 15 clean compares keep SUSPECT, the 16th returns to MONITOR
    for (int i = 0; i < 15; i++) issue(4'h3, 4'h4, OP_ADD, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check_output("window15_state", {14'b0, state}, 16'd1);
    issue(4'h5, 4'hA, OP_OR, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check_output("window16_state", {14'b0, state}, 16'd0);

    // Strikes restart at 1: two later mismatches must not reach the threshold
    issue(4'h8, 4'h1, OP_SUB, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    check_output("restrike1_state", {14'b0, state}, 16'd1);
    issue(4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check_output("restrike2_state", {14'b0, state}, 16'd1);
    apply_stimulus(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check_output("clear_in_suspect_state", {14'b0, state}, 16'd0);

    // Three bad among five back-to-back issues raises the alarm
    issue(4'h8, 4'h8, OP_ADD, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(4'h9, 4'h6, OP_ADD, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'h5, 4'h5, OP_SUB, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h0, 4'h1, OP_SUB, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'hC, 4'hA, OP_AND, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    check_output("alarm_state", {14'b0, state}, 16'd2);
    check_output("alarm_raised", {15'b0, alarm}, 16'd1);
    for (int i = 0; i < 10; i++) issue(4'h5, 4'hA, OP_AND, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check_output("alarm_held", {15'b0, alarm}, 16'd1);
    check_output("alarm_held_state", {14'b0, state}, 16'd2);
`ifdef ALU_MON_CAPTURE_EN
    check_output("cap_valid_set", {15'b0, cap_valid}, 16'd1);
    check_output("cap_A", {12'b0, cap_A}, 16'h8);
    check_output("cap_B", {12'b0, cap_B}, 16'h8);
    check_output("cap_op", {14'b0, cap_op}, 16'd0);
    check_output("cap_result", {12'b0, cap_result}, 16'h0);
`endif

    // clear_alarm coincident with a mismatch: clear wins, mismatch still counted
    issue(4'hC, 4'hA, OP_OR, 4'hD, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check_output("clear_coincident_state", {14'b0, state}, 16'd0);
    check_output("clear_coincident_alarm", {15'b0, alarm}, 16'd0);
    check_output("clear_coincident_mcount", mismatch_count, 16'd7);
    check_output("total_checks", check_count, 16'd36);
`ifdef ALU_MON_CAPTURE_EN
    check_output("clear_coincident_cap_valid", {15'b0, cap_valid}, 16'd0);
`endif

    // Reset right after an issue: the pending wrong response is never compared
    issue(4'hF, 4'h1, OP_ADD, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    check_output("post_reset_checks", check_count, 16'd0);
    check_output("post_reset_mcount", mismatch_count, 16'd0);
    check_output("post_reset_mismatch", {15'b0, mismatch}, 16'd0);
    check_output("post_reset_state", {14'b0, state}, 16'd0);
    check_output("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
